spi_cs_master: RTL and testbench
================================

Name: spi_cs_master

Overview:
- SPI master that drives the 4-bit slave-select `code` bus, SCLK and MOSI toward up to four SPI slaves.
- Takes in the single MISO line produced by the board-level MISO decoder, which selects one slave's MISO from the same `code` value.
- Encodes a 2-bit slave index into the 4-bit select code and runs one full-duplex transfer per request.
- Sits between the modem control logic (register/command side) and the SPI peripheral bus.

Parameters:
DATA_W, 16, bits per transfer (≥2)
CLK_DIV, 4, clk cycles per SCLK half-period (≥1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  transfer request, sampled when busy=0
slave_sel  in  2  target slave index 0..3
tx_data  in  DATA_W  word to shift out
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer end
rx_data  out  DATA_W  last received word
code  out  4  slave-select code to SPI bus / MISO decoder
sclk  out  1  SPI clock, CPOL=0
mosi  out  1  serial data out
miso  in  1  decoded serial data in

Behaviour:
- Reset (async, rst_n=0), all forced immediately:
  - code=4'b1111 (idle; decoder returns MISO=1)
  - sclk=0, mosi=0, busy=0, done=0, rx_data=0, state=IDLE, divider=0.
- Slave code mapping (fixed, shared with the decoder):
  - idx0 → 4'b0011, idx1 → 4'b1101, idx2 → 4'b1011, idx3 → 4'b0111.
  - Any non-transfer state → 4'b1111.
- SPI mode 0, MSB first (see Optional Feature).
- States and transitions:
  - IDLE: if start=1 at edge N, latch tx_data and slave_sel, go to SETUP. busy=1, code=encoded value and mosi=tx_data[DATA_W-1] are all valid from cycle N+1. start while busy=1 is ignored (not queued).
  - SETUP: CLK_DIV cycles with sclk=0, then SHIFT.
  - SHIFT: sclk toggles every CLK_DIV clk cycles, giving DATA_W rising and DATA_W falling edges.
    - On each sclk rise, miso is sampled into the receive shift register.
    - On each sclk fall except the last, the next tx bit is driven on mosi.
    - After the DATA_W-th fall, go to HOLD.
  - HOLD: CLK_DIV cycles with sclk=0, then DONE.
  - DONE: single cycle. code returns to 4'b1111, busy=0, done=1, rx_data updated. Next state is IDLE.
- Latency: done is high in cycle N+(2*DATA_W+2)*CLK_DIV+1. With defaults (DATA_W=16, CLK_DIV=4) this is N+137.
- Back-to-back: start asserted in the DONE cycle is ignored. start is accepted from the first IDLE cycle after DONE, so code returns to 4'b1111 for at least one cycle between frames.
- rx_data holds its value between transfers. Only the DONE cycle writes it.
- Reset mid-transfer aborts the frame: no done pulse, rx_data cleared, code idle.
- slave_sel/tx_data changes during busy have no effect on the current frame.

Optional Feature:
- Macro: SPI_CS_MASTER_LSB_FIRST_EN.
- Defined: bits are transmitted and received LSB first. mosi starts at tx_data[0]. Received bits fill rx_data from bit 0 upward, so the first sampled bit lands in rx_data[0].
- Undefined: MSB first as above.
- Timing is identical in both builds.

Decomposition:
- Package spi_cs_pkg:
  - Code constants CODE_S0=4'b0011, CODE_S1=4'b1101, CODE_S2=4'b1011, CODE_S3=4'b0111, CODE_IDLE=4'b1111.
  - State enum IDLE/SETUP/SHIFT/HOLD/DONE.
  - The MISO decoder should use the same code constants.
- Sub-module spi_clk_tick: divider counter producing a one-cycle tick every CLK_DIV clk cycles while enabled, cleared when disabled. The FSM uses the ticks for phase advance and sclk toggling.

Test Plan:
1. Reset then idle:
   - rst_n low 3 cycles, release → code=4'b1111, sclk=0, busy=0, done=0, rx_data=0.
   - No start for 50 cycles → outputs unchanged.
2. Basic transfer with loopback:
   - slave_sel=2, tx_data=16'hA5C3, miso tied to mosi, start pulse at N.
   - code=4'b1011 from N+1 to N+136; 16 sclk rises.
   - done at N+137 with rx_data=16'hA5C3; code=4'b1111 at N+137.
3. Code mapping:
   - Run transfers with slave_sel=0,1,3 → code=4'b0011, 4'b1101, 4'b0111 respectively during busy.
   - Slave model returns 16'h1234/16'hBEEF/16'h0F0F → rx_data matches each.
4. Busy protection:
   - start held high for the whole frame with tx_data changed to 16'hFFFF mid-frame.
   - Exactly one done in the frame; original word shifted out.
   - Next frame starts from the first IDLE cycle after DONE, not in the DONE cycle.
5. Reset mid-transfer:
   - Assert rst_n low at cycle N+60 → same cycle: code=4'b1111, sclk=0, busy=0.
   - No done pulse; rx_data=0.
6. LSB-first build (SPI_CS_MASTER_LSB_FIRST_EN defined):
   - tx_data=16'h0001 → first mosi bit =1.
   - Loopback rx_data=16'h0001; done still at N+137.

Source files
------------

// File: rtl/spi_cs_pkg.sv
// Shared definitions for the SPI chip-select master: slave-select codes,
// FSM state encoding and code encode/decode helpers used by master and MISO decoder.
package spi_cs_pkg;

  localparam logic [3:0] CODE_S0   = 4'b0011;
  localparam logic [3:0] CODE_S1   = 4'b1101;
  localparam logic [3:0] CODE_S2   = 4'b1011;
  localparam logic [3:0] CODE_S3   = 4'b0111;
  localparam logic [3:0] CODE_IDLE = 4'b1111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } slave_dec_t;

  function automatic logic [3:0] encode_slave(input logic [1:0] idx);
    logic [3:0] c;
    case (idx)
      2'd0:    c = CODE_S0;
      2'd1:    c = CODE_S1;
      2'd2:    c = CODE_S2;
      2'd3:    c = CODE_S3;
      default: c = CODE_IDLE;
    endcase
    return c;
  endfunction

  // Inverse mapping as seen by the MISO decoder; any unknown code selects nobody.
  function automatic slave_dec_t decode_code(input logic [3:0] code);
    slave_dec_t d;
    case (code)
      CODE_S0: d = '{valid: 1'b1, idx: 2'd0};
      CODE_S1: d = '{valid: 1'b1, idx: 2'd1};
      CODE_S2: d = '{valid: 1'b1, idx: 2'd2};
      CODE_S3: d = '{valid: 1'b1, idx: 2'd3};
      default: d = '{valid: 1'b0, idx: 2'd0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Free-running SCLK phase divider: one-cycle tick every CLK_DIV clk cycles
// while enabled; the count is held at zero whenever disabled.
module spi_clk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_cs_master.sv
// SPI mode-0 master with 4-bit encoded slave select; one full-duplex frame per start.
// Define SPI_CS_MASTER_LSB_FIRST_EN for LSB-first shifting (timing unchanged).
module spi_cs_master
  import spi_cs_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        slave_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic [3:0]        code,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              sclk_q, sclk_d;
  logic [3:0]        code_q, code_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              div_en_s;
  logic              tick_s;
  logic              last_bit_s;
  logic [DATA_W-1:0] tx_shift_s;
  logic [DATA_W-1:0] rx_shift_s;
  logic              mosi_s;

  assign div_en_s   = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign last_bit_s = (bit_cnt_q == BIT_LAST);

  spi_clk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_tick (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (div_en_s),
    .tick_o (tick_s)
  );

  // mosi comes straight from the end of the tx shift register that leaves first
`ifdef SPI_CS_MASTER_LSB_FIRST_EN
  assign mosi_s     = tx_sr_q[0];
  assign tx_shift_s = {1'b0, tx_sr_q[DATA_W-1:1]};
  assign rx_shift_s = {miso, rx_sr_q[DATA_W-1:1]};
`else
  assign mosi_s     = tx_sr_q[DATA_W-1];
  assign tx_shift_s = {tx_sr_q[DATA_W-2:0], 1'b0};
  assign rx_shift_s = {rx_sr_q[DATA_W-2:0], miso};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_sr_q   <= {DATA_W{1'b0}};
      rx_sr_q   <= {DATA_W{1'b0}};
      rx_data_q <= {DATA_W{1'b0}};
      bit_cnt_q <= {BIT_W{1'b0}};
      sclk_q    <= 1'b0;
      code_q    <= CODE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = SETUP;
        else       state_d = IDLE;
      end
      SETUP: begin
        if (tick_s) state_d = SHIFT;
        else        state_d = SETUP;
      end
      SHIFT: begin
        if (tick_s && sclk_q && last_bit_s) state_d = HOLD;
        else                                state_d = SHIFT;
      end
      HOLD: begin
        if (tick_s) state_d = DONE;
        else        state_d = HOLD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed one cycle ahead so they line up with state_q.
  always_comb begin
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    code_d    = code_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        if (start) begin
          tx_sr_d   = tx_data;
          rx_sr_d   = {DATA_W{1'b0}};
          bit_cnt_d = {BIT_W{1'b0}};
          code_d    = encode_slave(slave_sel);
          busy_d    = 1'b1;
        end else begin
          code_d = CODE_IDLE;
          busy_d = 1'b0;
        end
      end
      SETUP: begin
        sclk_d = 1'b0;
      end
      SHIFT: begin
        if (tick_s) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sr_d = rx_shift_s;
          end else begin
            sclk_d = 1'b0;
            // The final falling edge leaves mosi on the last bit.
            if (last_bit_s) begin
              bit_cnt_d = bit_cnt_q;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              tx_sr_d   = tx_shift_s;
            end
          end
        end else begin
          sclk_d = sclk_q;
        end
      end
      HOLD: begin
        sclk_d = 1'b0;
        if (tick_s) begin
          code_d    = CODE_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          tx_sr_d   = {DATA_W{1'b0}};
        end else begin
          done_d = 1'b0;
        end
      end
      DONE: begin
        sclk_d = 1'b0;
        code_d = CODE_IDLE;
        busy_d = 1'b0;
      end
      default: begin
        sclk_d  = 1'b0;
        code_d  = CODE_IDLE;
        busy_d  = 1'b0;
        tx_sr_d = {DATA_W{1'b0}};
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign code    = code_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_s;

endmodule

// File: tb/tb_spi_cs_master.sv
// Scoreboard bench for spi_cs_master: expected words and done cycles are queued at
// start and checked by a monitor when done pulses.
module tb_spi_cs_master;

  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 4;
  localparam int LAT     = (2 * DATA_W + 2) * CLK_DIV;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        slave_sel = 2'd0;
  logic [DATA_W-1:0] tx_data = 16'h0000;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic [3:0]        code;
  logic              sclk;
  logic              mosi;
  logic              miso;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic              loopback = 1'b1;
  logic [DATA_W-1:0] slv_sr = 16'h0000;
  logic [DATA_W-1:0] exp_rx_q[$];
  int                exp_cyc_q[$];
  logic [DATA_W-1:0] mon_rx;
  int                mon_cyc;

  spi_cs_master #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .slave_sel(slave_sel), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .code(code), .sclk(sclk),
    .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: presents its word on miso, advancing on each sclk fall.
`ifdef SPI_CS_MASTER_LSB_FIRST_EN
  assign miso = loopback ? mosi : ((code == 4'b1111) ? 1'b1 : slv_sr[0]);
  always @(negedge sclk) if (!loopback) slv_sr <= {1'b0, slv_sr[DATA_W-1:1]};
`else
  assign miso = loopback ? mosi : ((code == 4'b1111) ? 1'b1 : slv_sr[DATA_W-1]);
  always @(negedge sclk) if (!loopback) slv_sr <= {slv_sr[DATA_W-2:0], 1'b0};
`endif

  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_rx_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done at cyc %0d", cyc);
      end else begin
        mon_rx  = exp_rx_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        if (rx_data !== mon_rx) begin
          errors++;
          $display("FAIL rx_data got %h expected %h", rx_data, mon_rx);
        end
        checks++;
        if (cyc !== mon_cyc) begin
          errors++;
          $display("FAIL done_latency got cyc %0d expected cyc %0d", cyc, mon_cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] sel, input logic [DATA_W-1:0] word,
                             input logic [DATA_W-1:0] exp_word, output int n);
    tick();
    slave_sel = sel;
    tx_data   = word;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n = cyc;
    exp_rx_q.push_back(exp_word);
    exp_cyc_q.push_back(n + LAT);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || done) && t < 400) begin
      tick();
      t++;
    end
    checks++;
    if (busy || done) begin
      errors++;
      $display("FAIL wait_idle timeout busy %b done %b", busy, done);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (code !== 4'b1111) begin errors++; $display("FAIL reset_code got %b expected 1111", code); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b expected 0", sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (rx_data !== 16'h0000) begin errors++; $display("FAIL reset_rx got %h expected 0000", rx_data); end
    for (int i = 0; i < 50; i++) begin
      if (code !== 4'b1111 || sclk !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rx_data !== 16'h0000) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_stable got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_basic();
    int n, rises = 0, bad = 0;
    logic prev;
    loopback = 1'b1;
    start_frame(2'd2, 16'hA5C3, 16'hA5C3, n);
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL basic_first_mosi got %b expected 1", mosi); end
    prev = sclk;
    for (int k = 1; k <= LAT; k++) begin
      if (code !== 4'b1011 || busy !== 1'b1) bad++;
      if (sclk && !prev) rises++;
      prev = sclk;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_code_busy got %0d bad cycles expected 0", bad); end
    checks++; if (rises != 16) begin errors++; $display("FAIL basic_sclk_rises got %0d expected 16", rises); end
    checks++; if (code !== 4'b1111) begin errors++; $display("FAIL basic_done_code got %b expected 1111", code); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_busy got done %b busy %b expected 1 0", done, busy); end
    wait_idle();
  endtask

  task automatic test_code_map();
    logic [1:0]  sels  [3] = '{2'd0, 2'd1, 2'd3};
    logic [15:0] words [3] = '{16'h1234, 16'hBEEF, 16'h0F0F};
    logic [3:0]  codes [3] = '{4'b0011, 4'b1101, 4'b0111};
    int n;
    loopback = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slv_sr = words[i];
      start_frame(sels[i], 16'h5A5A, words[i], n);
      checks++;
      if (code !== codes[i]) begin errors++; $display("FAIL map_code_start sel %0d got %b expected %b", sels[i], code, codes[i]); end
      repeat (68) tick();
      checks++;
      if (code !== codes[i] || busy !== 1'b1) begin errors++; $display("FAIL map_code_mid sel %0d got %b busy %b expected %b 1", sels[i], code, busy, codes[i]); end
      wait_idle();
    end
    loopback = 1'b1;
  endtask

  task automatic test_busy();
    int n, dones = 0;
    loopback = 1'b1;
    tick();
    slave_sel = 2'd1;
    tx_data   = 16'h3C5A;
    start     = 1'b1;
    tick();
    n = cyc;
    exp_rx_q.push_back(16'h3C5A);
    exp_cyc_q.push_back(n + LAT);
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k == 40) tx_data = 16'hFFFF;
      if (done) dones++;
      tick();
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL busy_done_count got %0d expected 1", dones); end
    checks++; if (busy !== 1'b0 || code !== 4'b1111) begin errors++; $display("FAIL busy_gap got busy %b code %b expected 0 1111", busy, code); end
    exp_rx_q.push_back(16'hFFFF);
    exp_cyc_q.push_back(n + LAT + 2 + LAT);
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || code !== 4'b1101) begin errors++; $display("FAIL busy_restart got busy %b code %b expected 1 1101", busy, code); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n, dones = 0;
    logic [DATA_W-1:0] dummy;
    int dummy_c;
    loopback = 1'b1;
    start_frame(2'd0, 16'h1357, 16'h1357, n);
    repeat (59) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (code !== 4'b1111) begin errors++; $display("FAIL midrst_code got %b expected 1111", code); end
    checks++; if (sclk !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_sclk_busy got %b %b expected 0 0", sclk, busy); end
    checks++; if (rx_data !== 16'h0000) begin errors++; $display("FAIL midrst_rx got %h expected 0000", rx_data); end
    dummy   = exp_rx_q.pop_back();
    dummy_c = exp_cyc_q.pop_back();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if (done) dones++;
      tick();
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses expected 0", dones); end
    checks++; if (rx_data !== 16'h0000) begin errors++; $display("FAIL midrst_rx_after got %h expected 0000", rx_data); end
  endtask

  task automatic test_bit_order();
    int n;
    logic exp_first;
`ifdef SPI_CS_MASTER_LSB_FIRST_EN
    exp_first = 1'b1;
`else
    exp_first = 1'b0;
`endif
    loopback = 1'b1;
    start_frame(2'd3, 16'h0001, 16'h0001, n);
    checks++;
    if (mosi !== exp_first) begin errors++; $display("FAIL bit_order_first_mosi got %b expected %b", mosi, exp_first); end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_code_map();
    test_busy();
    test_reset_mid();
    test_bit_order();
    repeat (5) tick();
    checks++;
    if (exp_rx_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d expected 0", exp_rx_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
